// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for cpu_4bit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath strobe and mux select, with a retired-instruction counter.
package custom_types;
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_ADDI = 4'd5,
    OP_SUBI = 4'd6,
    OP_LSLI = 4'd7,
    OP_MOV  = 4'd8,
    OP_MOVI = 4'd9,
    OP_LD   = 4'd10,
    OP_ST   = 4'd11,
    OP_JMP  = 4'd12,
    OP_BEQ  = 4'd13,
    OP_BNE  = 4'd14
  } opcode_t;
endpackage

// state      | meaning
// FETCH      | load IR from instr_mem[pc], pc + 1
// DECODE     | branch resolution, dispatch on live opcode
// EXECUTE    | ALU result captured
// MEM_READ   | data_mem addressed by rs
// MEM_WRITE  | data_mem[rs1] <= rs2
// WRITEBACK  | reg_file[rd] written, zero flag updated for ALU ops
// HALT       | illegal opcode seen; sticky until reset
module cpu_control_fsm
  import custom_types::*;
(
  input  logic        cpu_clk,
  input  logic        cpu_reset_n,
  input  opcode_t     opcode,
  input  logic        zero_flag,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        reg_we,
  output logic        zero_we,
  output logic        mem_we,
  output logic        alu_out_load,
  output logic [2:0]  alu_op,
  output logic        alu_b_sel,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        instr_done,
  output logic [7:0]  instr_count,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_READ  = 3'd3,
    S_MEM_WRITE = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd7
  } state_t;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_LSL    = 3'd5;
  localparam logic [2:0] ALU_PASS_B = 3'd6;

  state_t  state_q;
  state_t  state_d;
  opcode_t op_q;

  function automatic logic [2:0] alu_map(input opcode_t op);
    case (op)
      OP_ADD, OP_ADDI: alu_map = ALU_ADD;
      OP_SUB, OP_SUBI: alu_map = ALU_SUB;
      OP_AND:          alu_map = ALU_AND;
      OP_OR:           alu_map = ALU_OR;
      OP_XOR:          alu_map = ALU_XOR;
      OP_LSLI:         alu_map = ALU_LSL;
      OP_MOV, OP_MOVI: alu_map = ALU_PASS_B;
      default:         alu_map = ALU_ADD;
    endcase
  endfunction

  function automatic logic uses_imm(input opcode_t op);
    uses_imm = (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LSLI) || (op == OP_MOVI);
  endfunction

  function automatic logic sets_zero(input opcode_t op);
    sets_zero = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR) ||
                (op == OP_XOR) || (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_LSLI);
  endfunction

  always_ff @(posedge cpu_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q     <= S_FETCH;
      op_q        <= OP_ADD;
      instr_count <= 8'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) op_q <= opcode;
      if (instr_done) instr_count <= instr_count + 8'd1;
    end
  end

  assign state = state_q;

  always_comb begin
    state_d      = state_q;
    ir_load      = 1'b0;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;
    reg_we       = 1'b0;
    zero_we      = 1'b0;
    mem_we       = 1'b0;
    alu_out_load = 1'b0;
    alu_op       = 3'd0;
    alu_b_sel    = 1'b0;
    wb_sel       = 1'b0;
    instr_done   = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_load = 1'b1;
        pc_inc  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branches resolve here against the live IR and flag; no later phase needed.
        case (opcode)
          OP_JMP: begin
            pc_load    = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_BEQ: begin
            pc_load    = zero_flag;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_BNE: begin
            pc_load    = !zero_flag;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_ST:   state_d = S_MEM_WRITE;
          OP_LD:   state_d = S_MEM_READ;
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
          OP_ADDI, OP_SUBI, OP_LSLI, OP_MOV, OP_MOVI:
                   state_d = S_EXECUTE;
          default: state_d = S_HALT;
        endcase
      end
      S_EXECUTE: begin
        alu_out_load = 1'b1;
        alu_op       = alu_map(op_q);
        alu_b_sel    = uses_imm(op_q);
        state_d      = S_WRITEBACK;
      end
      S_MEM_READ: state_d = S_WRITEBACK;
      S_MEM_WRITE: begin
        mem_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WRITEBACK: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        wb_sel     = (op_q == OP_LD);
        zero_we    = sets_zero(op_q);
        // LD lands here too; alu_map gives 0 for it, matching the idle value.
        alu_op     = (op_q == OP_LD) ? 3'd0 : alu_map(op_q);
        alu_b_sel  = uses_imm(op_q);
        state_d    = S_FETCH;
      end
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_HALT;
    endcase
    // Async reset must silence strobes immediately, not at the next edge.
    if (!cpu_reset_n) begin
      ir_load      = 1'b0;
      pc_inc       = 1'b0;
      pc_load      = 1'b0;
      reg_we       = 1'b0;
      zero_we      = 1'b0;
      mem_we       = 1'b0;
      alu_out_load = 1'b0;
      alu_op       = 3'd0;
      alu_b_sel    = 1'b0;
      wb_sel       = 1'b0;
      instr_done   = 1'b0;
      halted       = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: per-cycle expected output vectors are queued
// when each instruction is issued and popped/compared as the DUT steps through it.
module tb_cpu_control_fsm;
  import custom_types::*;

  logic       cpu_clk = 1'b0;
  logic       cpu_reset_n;
  opcode_t    opcode;
  logic       zero_flag;
  logic       ir_load, pc_inc, pc_load, reg_we, zero_we, mem_we, alu_out_load;
  logic [2:0] alu_op;
  logic       alu_b_sel, wb_sel;
  logic [2:0] state;
  logic       instr_done;
  logic [7:0] instr_count;
  logic       halted;

  cpu_control_fsm dut (
    .cpu_clk(cpu_clk), .cpu_reset_n(cpu_reset_n), .opcode(opcode), .zero_flag(zero_flag),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .reg_we(reg_we),
    .zero_we(zero_we), .mem_we(mem_we), .alu_out_load(alu_out_load), .alu_op(alu_op),
    .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .state(state), .instr_done(instr_done),
    .instr_count(instr_count), .halted(halted)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_load, pc_inc, pc_load, reg_we, zero_we, mem_we, alu_out_load;
    logic [2:0] alu_op;
    logic       alu_b_sel, wb_sel, instr_done, halted;
    logic [7:0] cnt;
  } obs_t;

  obs_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_count = 8'd0;

  function automatic obs_t sample_dut();
    obs_t o;
    o.st = state; o.ir_load = ir_load; o.pc_inc = pc_inc; o.pc_load = pc_load;
    o.reg_we = reg_we; o.zero_we = zero_we; o.mem_we = mem_we;
    o.alu_out_load = alu_out_load; o.alu_op = alu_op; o.alu_b_sel = alu_b_sel;
    o.wb_sel = wb_sel; o.instr_done = instr_done; o.halted = halted; o.cnt = instr_count;
    return o;
  endfunction

  function automatic logic [2:0] ref_alu(input logic [3:0] op);
    case (op)
      4'd0, 4'd5: return 3'd0;
      4'd1, 4'd6: return 3'd1;
      4'd2:       return 3'd2;
      4'd3:       return 3'd3;
      4'd4:       return 3'd4;
      4'd7:       return 3'd5;
      4'd8, 4'd9: return 3'd6;
      default:    return 3'd0;
    endcase
  endfunction

  function automatic int cycles_of(input logic [3:0] op);
    if (op >= 4'd12 && op <= 4'd14) return 2;
    if (op == 4'd11) return 3;
    if (op == 4'd15) return 22;
    return 4;
  endfunction

  // Expected outputs for cycle k (0 = FETCH) of instruction op.
  function automatic obs_t model_cycle(input logic [3:0] op, input int k, input logic zf,
                                       input logic [7:0] cnt);
    obs_t e;
    logic imm;
    e = '0;
    e.cnt = cnt;
    imm = (op == 4'd5) || (op == 4'd6) || (op == 4'd7) || (op == 4'd9);
    if (k == 0) begin
      e.st = 3'd0; e.ir_load = 1'b1; e.pc_inc = 1'b1;
    end else if (k == 1) begin
      e.st = 3'd1;
      if (op == 4'd12) begin e.pc_load = 1'b1; e.instr_done = 1'b1; end
      if (op == 4'd13) begin e.pc_load = zf;   e.instr_done = 1'b1; end
      if (op == 4'd14) begin e.pc_load = !zf;  e.instr_done = 1'b1; end
    end else if (op == 4'd15) begin
      e.st = 3'd7; e.halted = 1'b1;
    end else if (op == 4'd11) begin
      e.st = 3'd4; e.mem_we = 1'b1; e.instr_done = 1'b1;
    end else if (op == 4'd10) begin
      if (k == 2) e.st = 3'd3;
      else begin e.st = 3'd5; e.reg_we = 1'b1; e.wb_sel = 1'b1; e.instr_done = 1'b1; end
    end else begin
      e.alu_op = ref_alu(op); e.alu_b_sel = imm;
      if (k == 2) begin e.st = 3'd2; e.alu_out_load = 1'b1; end
      else begin
        e.st = 3'd5; e.reg_we = 1'b1; e.instr_done = 1'b1;
        e.zero_we = !(op == 4'd8 || op == 4'd9);
      end
    end
    return e;
  endfunction

  task automatic check_obs(input string tag, input obs_t obs, input obs_t exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic pop_check(input string tag);
    obs_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check_obs(tag, sample_dut(), e);
    end
  endtask

  // Called just after the edge that enters FETCH; returns just after the edge of the next FETCH.
  task automatic run_instr(input logic [3:0] op, input logic zf, input string tag);
    int n;
    obs_t e;
    n = cycles_of(op);
    opcode = opcode_t'(op);
    zero_flag = zf;
    for (int k = 0; k < n; k++) begin
      e = model_cycle(op, k, zf, exp_count);
      sb.push_back(e);
      if (e.instr_done) exp_count = exp_count + 8'd1;
    end
    for (int k = 0; k < n; k++) begin
      @(negedge cpu_clk);
      pop_check($sformatf("%s_c%0d", tag, k + 1));
      @(posedge cpu_clk);
      #1;
      // Scramble the IR after DECODE; later phases must follow the captured opcode.
      if (k == 1) begin
        opcode = opcode_t'(op ^ 4'h3);
        zero_flag = !zf;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t zero_obs;
    zero_obs = '0;
    cpu_reset_n = 1'b0;
    opcode = OP_ADD;
    zero_flag = 1'b0;
    repeat (2) @(posedge cpu_clk);
    @(negedge cpu_clk);
    check_obs("reset_state", sample_dut(), zero_obs);
    @(posedge cpu_clk);
    #1;
    cpu_reset_n = 1'b1;

    run_instr(4'd9,  1'b0, "movi");
    check_val("count_after_movi", instr_count, 8'd1);
    run_instr(4'd1,  1'b0, "sub");
    run_instr(4'd11, 1'b0, "st");
    check_val("count_after_st", instr_count, 8'd3);
    run_instr(4'd14, 1'b0, "bne_z0");
    run_instr(4'd14, 1'b1, "bne_z1");
    run_instr(4'd13, 1'b0, "beq_z0");
    run_instr(4'd13, 1'b1, "beq_z1");
    run_instr(4'd12, 1'b0, "jmp_z0");
    run_instr(4'd12, 1'b1, "jmp_z1");
    run_instr(4'd10, 1'b0, "ld");
    run_instr(4'd5,  1'b1, "addi");
    run_instr(4'd7,  1'b0, "lsli");
    run_instr(4'd2,  1'b0, "and");
    run_instr(4'd3,  1'b1, "or");
    run_instr(4'd4,  1'b0, "xor");
    run_instr(4'd8,  1'b0, "mov");
    run_instr(4'd0,  1'b1, "add");
    run_instr(4'd6,  1'b0, "subi");

    run_instr(4'd15, 1'b0, "illegal");
    check_val("count_in_halt", instr_count, exp_count);
    cpu_reset_n = 1'b0;
    #1;
    check_obs("reset_from_halt", sample_dut(), zero_obs);
    exp_count = 8'd0;
    @(posedge cpu_clk);
    #1;
    cpu_reset_n = 1'b1;

    run_instr(4'd8, 1'b0, "mov_after_halt");
    opcode = OP_ADD;
    @(posedge cpu_clk);
    #1;
    @(posedge cpu_clk);
    #1;
    check_val("mid_exec_state", {5'd0, state}, 8'd2);
    check_val("mid_exec_alu_load", {7'd0, alu_out_load}, 8'd1);
    cpu_reset_n = 1'b0;
    #1;
    check_obs("reset_mid_exec", sample_dut(), zero_obs);
    exp_count = 8'd0;
    @(posedge cpu_clk);
    #1;
    cpu_reset_n = 1'b1;

    for (int i = 0; i < 256; i++) run_instr(4'd12, i[0], "jmp_wrap");
    check_val("count_wrap", instr_count, 8'd0);
    check_val("scoreboard_empty", 8'(sb.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
